// File: rtl/reg_file_pkg.sv
// Shared defaults and a popcount helper for the scoreboarded register file.
// No logic of its own; imported by reg_file_sb and reg_file_rdport.
package reg_file_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int MAX_DEPTH = 64;

  function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction
endpackage

// File: rtl/reg_file_rdport.sv
// Read port: register-select mux with same-cycle bypass override and hard-zero register 0.
// Latency: combinational. Backpressure: none; busy reports the pending bit of the addressed register.
// Reset forces data and busy to 0.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0] pending,
  input  logic [AW-1:0]    adr,
  input  logic             byp_vld,
  input  logic [WIDTH-1:0] byp_dat,
  input  logic             reset,
  output logic [WIDTH-1:0] dat,
  output logic             busy
);

  always_comb begin
    dat  = mem[adr];
    busy = pending[adr];
    // A write landing this cycle has already resolved the hazard.
    if (byp_vld) begin
      dat  = byp_dat;
      busy = 1'b0;
    end
    if (ZERO_R0 != 0 && adr == '0) begin
      dat  = '0;
      busy = 1'b0;
    end
    if (reset) begin
      dat  = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a per-register pending scoreboard and stall output.
// Latency: reads combinational, writes/pend bits/pend_cnt update at the clk edge. Backpressure: stall flags a pending source.
// Optional REG_FILE_SB_BYPASS_EN forwards the in-flight write data to matching read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    W_Adr,
  input  logic [WIDTH-1:0] W,
  input  logic [AW-1:0]    R_Adr,
  input  logic [AW-1:0]    S_Adr,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] S,
  input  logic             issue,
  input  logic [AW-1:0]    I_Adr,
  output logic             busy_R,
  output logic             busy_S,
  output logic             stall,
  output logic [AW:0]      pend_cnt
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]     pending;
  logic [DEPTH-1:0]     pend_set;
  logic [DEPTH-1:0]     pend_clr;
  logic [DEPTH-1:0]     pend_next;
  logic [MAX_DEPTH-1:0] pend_ext;
  logic [AW:0]          cnt_next;
  logic                 wr_en;
  logic                 byp_r;
  logic                 byp_s;
  int                   pop;

  assign wr_en = we && !(ZERO_R0 != 0 && W_Adr == '0);

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (we) pend_clr[W_Adr] = 1'b1;
    if (issue && !(ZERO_R0 != 0 && I_Adr == '0)) pend_set[I_Adr] = 1'b1;
    // Set after clear: a new producer to the same register wins.
    pend_next = (pending & ~pend_clr) | pend_set;
    pend_ext  = MAX_DEPTH'(pend_next);
    pop       = popcount(pend_ext);
    cnt_next  = (pop > DEPTH) ? (AW+1)'(DEPTH) : (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_en) mem[W_Adr] <= W;
      pending  <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  assign byp_r = wr_en && !reset && (W_Adr == R_Adr);
  assign byp_s = wr_en && !reset && (W_Adr == S_Adr);
`else
  assign byp_r = 1'b0;
  assign byp_s = 1'b0;
`endif

  reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0)) u_rd_r (
    .mem     (mem),
    .pending (pending),
    .adr     (R_Adr),
    .byp_vld (byp_r),
    .byp_dat (W),
    .reset   (reset),
    .dat     (R),
    .busy    (busy_R)
  );

  reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0)) u_rd_s (
    .mem     (mem),
    .pending (pending),
    .adr     (S_Adr),
    .byp_vld (byp_s),
    .byp_dat (W),
    .reset   (reset),
    .dat     (S),
    .busy    (busy_S)
  );

  assign stall = busy_R | busy_S;

endmodule
